spike_detector: RTL and testbench
=================================

Name: spike_detector

Overview:
Consumes the filtered sample stream produced by the IIR front-end (signed 11-bit, one sample per valid cycle) and detects spikes on the magnitude of that stream. It uses a high threshold with a minimum-run qualifier, ends a spike on a hysteresis low threshold, and then applies a refractory hold-off. It reports spike start/end pulses, an active flag, the peak magnitude of the last spike and a saturating spike counter.

Parameters:
W, 11, sample width; matches the filter output z
MIN_LEN, 3, consecutive above-threshold valid samples needed to declare a spike (>=1)
HYST, 16, hysteresis; low threshold = thresh - HYST, floored at 0
HOLDOFF, 8, valid samples ignored after spike end (0 allowed)
SETTLE, 4, valid samples ignored after reset (filter start-up transient; 0 allowed)
CNT_W, 16, spike counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  z is a new sample this cycle
z  in  W  signed filtered sample
thresh  in  W  unsigned high threshold, used live on every valid sample
spike_start  out  1  one-cycle pulse: spike qualified
spike_end  out  1  one-cycle pulse: spike ended
spike_active  out  1  high while in SPIKE
peak  out  W  unsigned max magnitude of current/last spike
spike_count  out  CNT_W  number of spikes, saturating

Behaviour:
- Reset (async, rst=1): state=SETTLE, all counters 0, all outputs 0. If SETTLE=0, the state leaves reset as IDLE.
- mag = |z| as unsigned W bits; z=-1024 gives mag=1024 with no overflow. thr_lo = (thresh>HYST) ? thresh-HYST : 0.
- Above test: mag > thresh (strict). Below test: mag < thr_lo (strict).
- in_valid=0: no state change, no counter advance, no pulses. in_valid gaps never break a run.
- All outputs are registered. Pulses appear in the cycle after the valid sample that causes them.
- States (all transitions occur only on valid samples):
  - SETTLE: count samples. After SETTLE samples -> IDLE. Input is ignored.
  - IDLE: above -> peak<=mag. If MIN_LEN=1 -> SPIKE with start actions; else run<=1 and -> QUAL.
  - QUAL: above -> peak<=max(peak,mag) and run++. When run reaches MIN_LEN -> SPIKE with start actions. Not above -> IDLE and run<=0; peak retains its value.
  - SPIKE: spike_active=1. Each sample: peak<=max(peak,mag). Below -> spike_end pulse; if HOLDOFF=0 -> IDLE, else -> HOLD with hold<=0.
  - HOLD: count samples. After HOLDOFF samples -> IDLE. Input is ignored.
- Start actions: spike_start pulse; spike_count += 1, saturating at all-ones (stays there, start pulse still fires).
- peak holds after spike_end until the next IDLE->QUAL/SPIKE entry reloads it.
- In SPIKE, a sample with thr_lo <= mag <= thresh keeps the spike alive.
- A thresh change takes effect on the next valid sample. No retroactive re-evaluation.
- Reset asserted in any state, including mid-spike: immediate return to reset values. No spike_end is emitted.

Test Plan:
- Reset, thresh=100, 4 valid samples of z=500 -> no spike_start (SETTLE). Outputs stay 0. The 5th..7th samples of 500 -> spike_start one cycle after the 7th sample, spike_count=1, spike_active=1, peak=500.
- After settle: z=50,150,160,170 -> spike_start after 170, peak=170. Then z=120,90,84 -> still active (thr_lo=84). Then z=83 -> spike_end pulse, spike_active=0, peak=170.
- After settle: z=150,150,90 -> no spike_start, spike_count unchanged, state back to IDLE. Then z=150 x3 -> spike_start.
- Hold-off: immediately after spike_end, 8 valid samples of z=500 -> no response. Next 3 samples of 500 -> spike_start. Insert in_valid=0 gaps of 5 cycles between samples -> identical outcome, only delayed.
- z=-1024 x3 with thresh=1000 -> spike_start, peak=1024. Then z=0 -> spike_end.
- Assert rst asynchronously mid-SPIKE (between clock edges) -> spike_active, peak, spike_count go to 0 immediately, with no spike_end. With CNT_W=2 override, 5 spikes -> spike_count=3 and 5 spike_start pulses.

Source files
------------

// File: rtl/spike_detector.sv
// Magnitude spike detector for the filtered sample stream: high threshold with a
// minimum-run qualifier, hysteresis end condition, refractory hold-off and peak capture.
module spike_detector #(
    parameter int W       = 11,
    parameter int MIN_LEN = 3,
    parameter int HYST    = 16,
    parameter int HOLDOFF = 8,
    parameter int SETTLE  = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     z,
    input  logic [W-1:0]     thresh,
    output logic             spike_start,
    output logic             spike_end,
    output logic             spike_active,
    output logic [W-1:0]     peak,
    output logic [CNT_W-1:0] spike_count
);

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_QUAL   = 3'd2,
        ST_SPIKE  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int MAX_A = (SETTLE > MIN_LEN) ? SETTLE : MIN_LEN;
    localparam int MAX_B = (MAX_A > HOLDOFF) ? MAX_A : HOLDOFF;
    localparam int MAX_C = (MAX_B > 1) ? MAX_B : 1;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
    localparam logic [CW-1:0] MIN_C     = CW'(MIN_LEN);
    localparam logic [CW-1:0] HOLDOFF_C = CW'(HOLDOFF);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam state_t        RST_STATE = (SETTLE > 0) ? ST_SETTLE : ST_IDLE;

    // Two's-complement magnitude; the most negative sample maps to 2^(W-1), which still fits unsigned.
    function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1'b1)) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     peak_q, peak_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start_q, start_d;
    logic             end_q, end_d;
    logic             active_q;

    logic [W-1:0]     mag_s;
    logic [W-1:0]     thr_lo_s;
    logic [W-1:0]     peak_max_s;
    logic [CW-1:0]    cnt_inc_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             above_s;
    logic             below_s;

    // Sample classification against the live thresholds.
    always_comb begin
        mag_s       = abs_mag(z);
        thr_lo_s    = (int'(thresh) > HYST) ? W'(int'(thresh) - HYST) : '0;
        above_s     = (mag_s > thresh);
        below_s     = (mag_s < thr_lo_s);
        peak_max_s  = (mag_s > peak_q) ? mag_s : peak_q;
        cnt_inc_s   = cnt_q + CNT_ONE;
        count_inc_s = (&count_q) ? count_q : (count_q + CNT_W'(1'b1));
    end

    // Next-state and registered-output decode; nothing moves without a valid sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        count_d = count_q;
        start_d = 1'b0;
        end_d   = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_inc_s >= SETTLE_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_IDLE: begin
                    if (above_s) begin
                        peak_d = mag_s;
                        if (MIN_LEN <= 1) begin
                            state_d = ST_SPIKE;
                            start_d = 1'b1;
                            count_d = count_inc_s;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_QUAL;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_QUAL: begin
                    if (above_s) begin
                        peak_d = peak_max_s;
                        if (cnt_inc_s >= MIN_C) begin
                            state_d = ST_SPIKE;
                            start_d = 1'b1;
                            count_d = count_inc_s;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        // A broken run abandons qualification but keeps the captured peak.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_SPIKE: begin
                    peak_d = peak_max_s;
                    if (below_s) begin
                        end_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = (HOLDOFF > 0) ? ST_HOLD : ST_IDLE;
                    end else begin
                        state_d = ST_SPIKE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_inc_s >= HOLDOFF_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            peak_q   <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            count_q  <= count_d;
            start_q  <= start_d;
            end_q    <= end_d;
            active_q <= (state_d == ST_SPIKE);
        end
    end

    assign spike_start  = start_q;
    assign spike_end    = end_q;
    assign spike_active = active_q;
    assign peak         = peak_q;
    assign spike_count  = count_q;

endmodule

// File: tb/tb_spike_detector.sv
// Scoreboard bench for spike_detector: directed sample sequences push expected
// start/end events; a monitor pops and checks them whenever either DUT pulses.
module tb_spike_detector;

    localparam int W = 11;

    typedef struct packed {
        logic        is_start;
        logic [10:0] peak;
        logic [15:0] cnt;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  z;
    logic [W-1:0]  thresh;
    logic          start1, end1, active1;
    logic [W-1:0]  peak1;
    logic [15:0]   count1;
    logic          start2, end2, active2;
    logic [W-1:0]  peak2;
    logic [1:0]    count2;

    ev_t q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  starts1 = 0;
    int  starts2 = 0;

    spike_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .z(z), .thresh(thresh),
        .spike_start(start1), .spike_end(end1), .spike_active(active1),
        .peak(peak1), .spike_count(count1)
    );

    spike_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .z(z), .thresh(thresh),
        .spike_start(start2), .spike_end(end2), .spike_active(active2),
        .peak(peak2), .spike_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_ev(input bit s, input int pk, input int c);
        ev_t e;
        e.is_start = s;
        e.peak     = 11'(pk);
        e.cnt      = 16'(c);
        q.push_back(e);
    endtask

    task automatic send(input int v, input int gap);
        z        = 11'(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_n(input int v, input int n, input int gap);
        for (int i = 0; i < n; i++) send(v, gap);
    endtask

    // Monitor: every pulse from either DUT must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (start1 || end1 || start2 || end2)) begin
            if (start1) starts1++;
            if (start2) starts2++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                ev_t e;
                int  c2;
                e  = q.pop_front();
                c2 = (int'(e.cnt) > 3) ? 3 : int'(e.cnt);
                chk("start_pulse",  int'(start1),  int'(e.is_start));
                chk("end_pulse",    int'(end1),    int'(!e.is_start));
                chk("active",       int'(active1), int'(e.is_start));
                chk("peak",         int'(peak1),   int'(e.peak));
                chk("count",        int'(count1),  int'(e.cnt));
                chk("sat_start",    int'(start2),  int'(e.is_start));
                chk("sat_end",      int'(end2),    int'(!e.is_start));
                chk("sat_peak",     int'(peak2),   int'(e.peak));
                chk("sat_count",    int'(count2),  c2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        z        = '0;
        thresh   = 11'd100;
        #12;
        chk("rst_active", int'(active1), 0);
        chk("rst_peak",   int'(peak1),   0);
        chk("rst_count",  int'(count1),  0);
        chk("rst_pulses", int'(start1 | end1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Settle window swallows the first four samples.
        send_n(500, 4, 0);
        send_n(500, 2, 0);
        exp_ev(1'b1, 500, 1);
        send(500, 0);
        exp_ev(1'b0, 500, 1);
        send(0, 0);
        // Hold-off ignores eight strong samples, then a fresh spike qualifies.
        send_n(500, 8, 0);
        send_n(500, 2, 0);
        exp_ev(1'b1, 500, 2);
        send(500, 0);
        exp_ev(1'b0, 500, 2);
        send(0, 0);
        // Same hold-off/qualify sequence with 5-cycle in_valid gaps.
        send_n(500, 8, 5);
        send_n(500, 2, 5);
        exp_ev(1'b1, 500, 3);
        send(500, 5);
        exp_ev(1'b0, 500, 3);
        send(0, 5);
        send_n(0, 8, 0);

        // Hysteresis: 84 keeps the spike alive, 83 ends it.
        send(50, 0);
        send(150, 0);
        send(160, 0);
        exp_ev(1'b1, 170, 4);
        send(170, 0);
        send(120, 0);
        send(90, 0);
        send(84, 0);
        chk("hyst_active", int'(active1), 1);
        exp_ev(1'b0, 170, 4);
        send(83, 0);
        send_n(0, 8, 0);

        // Broken run resets qualification.
        send(150, 0);
        send(150, 0);
        send(90, 0);
        chk("broken_run_count", int'(count1), 4);
        send_n(150, 2, 0);
        exp_ev(1'b1, 150, 5);
        send(150, 0);
        exp_ev(1'b0, 150, 5);
        send(0, 0);
        send_n(0, 8, 0);

        // Most negative sample.
        thresh = 11'd1000;
        send_n(-1024, 2, 0);
        exp_ev(1'b1, 1024, 6);
        send(-1024, 0);
        exp_ev(1'b0, 1024, 6);
        send(0, 0);
        send_n(0, 8, 0);

        // Async reset in the middle of a spike.
        thresh = 11'd100;
        send_n(500, 2, 0);
        exp_ev(1'b1, 500, 7);
        send(500, 0);
        #6;
        chk("pre_rst_active", int'(active1), 1);
        rst = 1'b1;
        #1;
        chk("async_active",    int'(active1), 0);
        chk("async_peak",      int'(peak1),   0);
        chk("async_count",     int'(count1),  0);
        chk("async_sat_count", int'(count2),  0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 3);

        chk("queue_drained",  q.size(), 0);
        chk("start_tally",    starts1, 7);
        chk("sat_start_tally", starts2, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
